// File: rtl/queue_pop_stage.sv
// Read-side pop stage: drains a register-file queue into a 2-entry (output + skid)
// registered valid/ready stream. Optional transfer counter via QUEUE_POP_STAGE_STATS_EN.
module queue_pop_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_q_empty_w,
    input  logic [W-1:0]     i_q_pop_dat,
    output logic             o_q_pop,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [W-1:0]     o_dat,
    input  logic             i_ready
`ifdef QUEUE_POP_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] o_xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e       state;
    logic [W-1:0] skid;
    logic         take;

    assign take    = o_valid & i_ready;
    assign o_q_pop = ~i_q_empty_w & ~i_flush & (state != S_TWO);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= S_EMPTY;
            o_valid <= 1'b0;
            o_dat   <= '0;
            skid    <= '0;
        end else if (i_flush) begin
            // Data registers keep their contents; they are don't-care while invalid.
            state   <= S_EMPTY;
            o_valid <= 1'b0;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (o_q_pop) begin
                        state   <= S_ONE;
                        o_valid <= 1'b1;
                        o_dat   <= i_q_pop_dat;
                    end
                end
                S_ONE: begin
                    if (o_q_pop && !take) begin
                        state <= S_TWO;
                        skid  <= i_q_pop_dat;
                    end else if (o_q_pop && take) begin
                        o_dat <= i_q_pop_dat;
                    end else if (take) begin
                        state   <= S_EMPTY;
                        o_valid <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (take) begin
                        state <= S_ONE;
                        o_dat <= skid;
                    end
                end
                default: begin
                    state   <= S_EMPTY;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef QUEUE_POP_STAGE_STATS_EN
    // Counts accepted transfers, including one accepted in a flush cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_xfer_cnt <= '0;
        end else if (take) begin
            o_xfer_cnt <= o_xfer_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_queue_pop_stage.sv
// Randomized bench for queue_pop_stage: an SV-queue upstream source and a list model of
// the held entries predict valid/data/pop each cycle. Define QUEUE_POP_STAGE_STATS_EN to cover the counter.
module tb_queue_pop_stage;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic             i_q_empty_w = 1'b1;
    logic [W-1:0]     i_q_pop_dat = '0;
    logic             o_q_pop;
    logic             i_flush = 1'b0;
    logic             o_valid;
    logic [W-1:0]     o_dat;
    logic             i_ready = 1'b0;
`ifdef QUEUE_POP_STAGE_STATS_EN
    logic [CNT_W-1:0] o_xfer_cnt;
`endif

    queue_pop_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .arst       (arst),
        .i_q_empty_w(i_q_empty_w),
        .i_q_pop_dat(i_q_pop_dat),
        .o_q_pop    (o_q_pop),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_dat      (o_dat),
        .i_ready    (i_ready)
`ifdef QUEUE_POP_STAGE_STATS_EN
        ,
        .o_xfer_cnt (o_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] src[$];   // upstream queue contents
    logic [W-1:0] held[$];  // entries the stage should currently hold, oldest first
    int unsigned  xfers;
    bit           dat_zero; // o_dat still at its reset value
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        held.delete();
        xfers    = 0;
        dat_zero = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        arst = 1'b0;
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic rdy, input logic fl);
        logic exp_pop, exp_take;
        @(negedge clk);
        i_ready     = rdy;
        i_flush     = fl;
        i_q_empty_w = (src.size() == 0);
        i_q_pop_dat = (src.size() != 0) ? src[0] : W'($urandom);
        #1;
        exp_pop  = (src.size() != 0) && !fl && (held.size() < 2);
        exp_take = (held.size() != 0) && rdy;
        check("valid", {63'd0, o_valid}, {63'd0, held.size() != 0});
        check("pop", {63'd0, o_q_pop}, {63'd0, exp_pop});
        if (held.size() != 0) check("dat", 64'(o_dat), 64'(held[0]));
        else if (dat_zero) check("dat_rst", 64'(o_dat), 64'd0);
`ifdef QUEUE_POP_STAGE_STATS_EN
        check("cnt", 64'(o_xfer_cnt), 64'(xfers % (1 << CNT_W)));
`endif
        @(posedge clk);
        if (exp_take) begin
            xfers++;
            void'(held.pop_front());
        end
        if (fl) held.delete();
        if (exp_pop) begin
            held.push_back(src.pop_front());
            dat_zero = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Idle after reset with an empty queue.
        repeat (4) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);

        // A,B,C streamed with ready held high.
        src = '{32'hA, 32'hB, 32'hC};
        repeat (6) step(1'b1, 1'b0);

        // A,B,C with ready low fills the skid, then drains in order.
        src = '{32'h1A, 32'h1B, 32'h1C};
        repeat (4) step(1'b0, 1'b0);
        check("skid_full", 64'(held.size()), 64'd2);
        repeat (5) step(1'b1, 1'b0);

        // Flush while full, then pops resume with the remaining head.
        src = '{32'h2A, 32'h2B, 32'h2C};
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0);

        // Asynchronous reset in S_ONE clears o_valid without a clock edge.
        src = '{32'h3A};
        repeat (2) step(1'b0, 1'b0);
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("arst_valid", {63'd0, o_valid}, 64'd0);
        check("arst_dat", 64'(o_dat), 64'd0);
        model_reset();
        src.delete();
        @(negedge clk);
        arst = 1'b0;
        repeat (2) step(1'b1, 1'b0);

        // 17 back-to-back transfers from reset (counter wraps to 1 with CNT_W=4).
        for (int i = 0; i < 17; i++) src.push_back(W'($urandom));
        repeat (20) step(1'b1, 1'b0);
`ifdef QUEUE_POP_STAGE_STATS_EN
        check("cnt_wrap", 64'(o_xfer_cnt), 64'd1);
        src = '{32'h55, 32'h66};
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("cnt_flush", 64'(o_xfer_cnt), 64'd1);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (src.size() < 3 && $urandom_range(0, 3) != 0)
                src.push_back(W'($urandom));
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
